// File: rtl/ariane_pkg.sv
// Shared types for the write-back arbiter: exception record and the
// per-requester write-back payload held in the arbiter's registers.
package ariane_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          data;
    exception_t               ex;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational find-first-set with a rotating start index; returns one-hot
// grant, its binary index and an any-request flag.
module wb_rr_picker #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] rr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int unsigned j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int unsigned o = 0; o < N; o++) begin
      // rr_i is always < N, so a single subtraction implements the wrap
      j = 32'(rr_i) + o;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j[IDX_W-1:0]]) begin
        any_o              = 1'b1;
        gnt_o[j[IDX_W-1:0]] = 1'b1;
        idx_o              = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one write-back port among NR_REQ producers.
// Define WB_ARB_STALL_CNT_EN to implement the per-requester stall counters.
module wb_port_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NR_REQ    = 3,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    flush_i,
  input  logic [NR_REQ-1:0]                       req_valid_i,
  output logic [NR_REQ-1:0]                       req_ready_o,
  input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]    req_trans_id_i,
  input  logic [NR_REQ-1:0][XLEN-1:0]             req_data_i,
  input  exception_t [NR_REQ-1:0]                 req_ex_i,
  output logic                                    wt_valid_o,
  output logic [TRANS_ID_BITS-1:0]                trans_id_o,
  output logic [XLEN-1:0]                         wbdata_o,
  output exception_t                              ex_o,
  output logic [NR_REQ-1:0][CNT_WIDTH-1:0]        stall_cnt_o
);

  localparam int unsigned IDX_W = $clog2(NR_REQ);

  logic [NR_REQ-1:0]   full_q, full_d;
  logic [NR_REQ-1:0]   grant, accept;
  wb_req_t [NR_REQ-1:0] entry_q, entry_d;
  wb_req_t             out_q, out_d;
  logic                wt_valid_q, wt_valid_d;
  logic [IDX_W-1:0]    rr_q, rr_d, gnt_idx;
  logic                gnt_any;

  wb_rr_picker #(
    .N     (NR_REQ),
    .IDX_W (IDX_W)
  ) i_picker (
    .req_i (full_q),
    .rr_i  (rr_q),
    .gnt_o (grant),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign req_ready_o = ~full_q | grant;
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    full_d     = full_q;
    entry_d    = entry_q;
    rr_d       = rr_q;
    wt_valid_d = 1'b0;
    out_d      = out_q;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      if (grant[i]) full_d[i] = 1'b0;
      // a refill in the grant cycle overrides the clear
      if (accept[i]) begin
        full_d[i]  = 1'b1;
        entry_d[i] = '{trans_id: req_trans_id_i[i], data: req_data_i[i], ex: req_ex_i[i]};
      end
    end
    if (flush_i) begin
      full_d = '0;
    end else if (gnt_any) begin
      wt_valid_d = 1'b1;
      out_d      = entry_q[gnt_idx];
      rr_d       = (gnt_idx == IDX_W'(NR_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q     <= '0;
      entry_q    <= '0;
      rr_q       <= '0;
      wt_valid_q <= 1'b0;
      out_q      <= '0;
    end else begin
      full_q     <= full_d;
      entry_q    <= entry_d;
      rr_q       <= rr_d;
      wt_valid_q <= wt_valid_d;
      out_q      <= out_d;
    end
  end

  assign wt_valid_o = wt_valid_q;
  assign trans_id_o = out_q.trans_id;
  assign wbdata_o   = out_q.data;
  assign ex_o       = out_q.ex;

`ifdef WB_ARB_STALL_CNT_EN
  logic [NR_REQ-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      if (full_q[i] && !grant[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_cnt_o = cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
